instr_decode_stage: RTL and testbench
=====================================

# instr_decode_stage

Buffered, parametrised instruction-decode stage for the RISC machine. A DEPTH-entry instruction queue feeds a registered decode slot with a valid/ready handshake on both sides. Decoded fields, including immediates sign-extended to DATA_W, are presented to the datapath controller. It sits between instruction fetch and the controller FSM and replaces direct combinational decoding of the instruction register.

## Interface
- DATA_W, 16 — width of the sign-extended immediates; must be ≥ 16
- DEPTH, 4 — queue entries; a power of two, ≥ 2
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous clear of the queue and the decode slot
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue can accept
- in_instr  in  16  instruction word: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], shift[4:3], Rm[2:0]
- out_valid  out  1  decode slot holds a decoded instruction
- out_ready  in  1  controller consumes the slot
- out_opcode  out  3  instr[15:13]
- out_op  out  2  instr[12:11]
- out_aluop  out  2  equals op
- out_shift  out  2  instr[4:3]
- out_rn, out_rd, out_rm  out  3 each  register indices
- out_imm8  out  DATA_W  sign-extended instr[7:0]
- out_imm5  out  DATA_W  sign-extended instr[4:0]
- out_illegal  out  1  undefined encoding (see Configuration)
- count  out  $clog2(DEPTH+1)  queue occupancy, excluding the slot

## Operation
- Push: in_valid && in_ready writes in_instr at the tail. in_ready = (count < DEPTH).
  - A full queue does not accept a push, even if a pop happens in the same cycle.
- Slot load: when the queue is non-empty and (!out_valid || out_ready), the head is popped and decoded into the slot, and out_valid is set.
  - Otherwise, if out_ready is high, out_valid clears.
- Hold: while out_valid && !out_ready, all out_* fields stay stable.
- Simultaneous push and pop on a non-full queue: count is unchanged, and both operations take effect.
- Pointers wrap modulo DEPTH.
- flush: count←0, pointers←0, out_valid←0. It has priority over push and over slot load in that cycle; an instruction offered in the same cycle is dropped.
- Reset (at any time, including mid-stream) returns to the reset state immediately; in-flight instructions are lost.
- Reset values:
  - out_valid 0, all decoded outputs 0, out_illegal 0
  - count 0
  - in_ready 1

## Timing
- Latency: an instruction accepted at edge E appears with out_valid=1 after edge E+1, provided the slot is free or draining.
- Throughput: one instruction per cycle when out_ready is held high.
- All outputs are registered, except in_ready, which is decoded from the count register only.
- No combinational path from out_ready or in_valid to any output.

## Configuration
- INSTR_DEC_ILLEGAL_EN defined: out_illegal is registered with the slot. It is 1 unless the instruction matches one of these legal encodings:
  - opcode 110 with op ∈ {10, 00}
  - opcode 101 with any op
  - opcode 011, 100 or 111 with op 00
- Undefined: out_illegal is tied to 0, and no illegal-detect logic is present.

## Structure
- Package instr_decode_pkg holds:
  - opcode and op encoding localparams (MOV, ALU, LDR, STR, HALT)
  - field bit-position constants
  - packed struct decoded_t for the slot contents
- Sub-module instr_fifo (parameters DEPTH and width 16) holds the queue storage, pointers and count.
- instr_decode_stage holds the slot register, the decode logic and the flush handling.

## Test plan
- Reset, then push 0xD0F9 with out_ready=1 → out_valid 1 two edges later with:
  - opcode 110, op 10, rn 0
  - imm8 0xFFF9
  - count 0
- Push 0xAAAA → fields decode as follows:
  - opcode 101, op/aluop 01, shift 01
  - rn 2, rd 5, rm 2
  - imm5 0x000A, imm8 0xFFAA
- Hold out_ready=0 and push six back-to-back (DEPTH=4) → five accepted (four queued plus one in the slot), count=4, in_ready 0. The slot holds the first instruction, unchanged. Then set out_ready=1 → the remaining five drain in order, one per cycle.
- Assert flush in the same cycle as a push while count=3 → the next cycle shows count 0, out_valid 0 and in_ready 1, and the flushed instructions never appear.
- With INSTR_DEC_ILLEGAL_EN defined, push 0x0000 and 0xD800 → out_illegal 1 for both, then push 0xA000 → out_illegal 0. Without the macro, out_illegal stays 0.
- With DATA_W=32, push 0xD0F9 → out_imm8 0xFFFF_FFF9. Assert reset mid-drain → all outputs are 0 immediately, and in_ready is 1 after reset is released.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// Shared encodings, field positions and slot layout for the decode stage.
// INSTR_DEC_ILLEGAL_EN enables undefined-encoding detection in decode().
package instr_decode_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_NONE    = 2'b00;

  localparam int OPC_LSB   = 13;
  localparam int OP_LSB    = 11;
  localparam int RN_LSB    = 8;
  localparam int RD_LSB    = 5;
  localparam int SHIFT_LSB = 3;
  localparam int RM_LSB    = 0;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] shift;
    logic [2:0] rm;
    logic [7:0] imm8;
    logic [4:0] imm5;
    logic       illegal;
  } decoded_t;

  function automatic logic is_legal(
    input logic [2:0] opc,
    input logic [1:0] op
  );
    case (opc)
      OPC_MOV:  is_legal = (op == OP_MOV_IMM) ||
                           (op == OP_MOV_REG);
      OPC_ALU:  is_legal = 1'b1;
      OPC_LDR,
      OPC_STR,
      OPC_HALT: is_legal = (op == OP_NONE);
      default:  is_legal = 1'b0;
    endcase
  endfunction

  function automatic decoded_t decode(
    input logic [INSTR_W-1:0] i
  );
    decoded_t d;
    d.opcode = i[OPC_LSB +: 3];
    d.op     = i[OP_LSB +: 2];
    d.rn     = i[RN_LSB +: 3];
    d.rd     = i[RD_LSB +: 3];
    d.shift  = i[SHIFT_LSB +: 2];
    d.rm     = i[RM_LSB +: 3];
    d.imm8   = i[7:0];
    d.imm5   = i[4:0];
`ifdef INSTR_DEC_ILLEGAL_EN
    d.illegal = !is_legal(d.opcode, d.op);
`else
    d.illegal = 1'b0;
`endif
    return d;
  endfunction

endpackage

// File: rtl/instr_decode_stage_fifo.sv
// Circular instruction queue: storage, wrapping pointers and occupancy.
// Flush clears pointers and count; a full queue refuses pushes outright.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 wdata_i,
  output logic [W-1:0]                 rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign push = push_i && (count_q < CW'(DEPTH));
  assign pop  = pop_i && (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_decode_stage.sv
// Queued decode stage: FIFO head is decoded into a registered output slot.
// INSTR_DEC_ILLEGAL_EN enables the registered out_illegal flag.
module instr_decode_stage
  import instr_decode_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_opcode,
  output logic [1:0]                 out_op,
  output logic [1:0]                 out_aluop,
  output logic [1:0]                 out_shift,
  output logic [2:0]                 out_rn,
  output logic [2:0]                 out_rd,
  output logic [2:0]                 out_rm,
  output logic [DATA_W-1:0]          out_imm8,
  output logic [DATA_W-1:0]          out_imm5,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [INSTR_W-1:0] head;
  logic               load;
  logic               valid_q, valid_d;
  decoded_t           slot_q, slot_d;

  instr_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .flush_i (flush),
    .push_i  (in_valid),
    .pop_i   (load),
    .wdata_i (in_instr),
    .rdata_o (head),
    .count_o (count)
  );

  assign in_ready = (count < CW'(DEPTH));
  assign load = !flush && (count != '0) &&
                (!valid_q || out_ready);

  always_comb begin
    valid_d = valid_q;
    slot_d  = slot_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      slot_d  = decode(head);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_opcode  = slot_q.opcode;
  assign out_op      = slot_q.op;
  assign out_aluop   = slot_q.op;
  assign out_shift   = slot_q.shift;
  assign out_rn      = slot_q.rn;
  assign out_rd      = slot_q.rd;
  assign out_rm      = slot_q.rm;
  assign out_imm8    = {{(DATA_W-8){slot_q.imm8[7]}}, slot_q.imm8};
  assign out_imm5    = {{(DATA_W-5){slot_q.imm5[4]}}, slot_q.imm5};
  assign out_illegal = slot_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage (DATA_W 16 and 32 side by side).
// Expected out_illegal follows INSTR_DEC_ILLEGAL_EN.
module tb_instr_decode_stage;

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [15:0] in_instr;

  logic        in_ready, out_valid, out_illegal;
  logic [2:0]  out_opcode, out_rn, out_rd, out_rm;
  logic [1:0]  out_op, out_aluop, out_shift;
  logic [15:0] out_imm8, out_imm5;
  logic [2:0]  count;

  logic        w_in_ready, w_out_valid, w_out_illegal;
  logic [2:0]  w_out_opcode, w_out_rn, w_out_rd, w_out_rm;
  logic [1:0]  w_out_op, w_out_aluop, w_out_shift;
  logic [31:0] w_out_imm8, w_out_imm5;
  logic [2:0]  w_count;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef INSTR_DEC_ILLEGAL_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_decode_stage #(.DATA_W(16), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_op(out_op), .out_aluop(out_aluop),
    .out_shift(out_shift), .out_rn(out_rn), .out_rd(out_rd),
    .out_rm(out_rm), .out_imm8(out_imm8), .out_imm5(out_imm5),
    .out_illegal(out_illegal), .count(count)
  );

  instr_decode_stage #(.DATA_W(32), .DEPTH(4)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_opcode(w_out_opcode), .out_op(w_out_op),
    .out_aluop(w_out_aluop), .out_shift(w_out_shift),
    .out_rn(w_out_rn), .out_rd(w_out_rd), .out_rm(w_out_rm),
    .out_imm8(w_out_imm8), .out_imm5(w_out_imm5),
    .out_illegal(w_out_illegal), .count(w_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] vals [6];

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; in_instr = 16'h0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_opcode", out_opcode, 0);
    chk("rst_imm8", out_imm8, 0);
    chk("rst_illegal", out_illegal, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // single instruction latency and decode
    in_valid = 1'b1; in_instr = 16'hD0F9;
    tick();
    in_valid = 1'b0;
    chk("t1_valid_early", out_valid, 0);
    chk("t1_count_q", count, 1);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_opcode", out_opcode, 3'b110);
    chk("t1_op", out_op, 2'b10);
    chk("t1_rn", out_rn, 0);
    chk("t1_rd", out_rd, 7);
    chk("t1_rm", out_rm, 1);
    chk("t1_imm8", out_imm8, 16'hFFF9);
    chk("t1_imm5", out_imm5, 16'hFFF9);
    chk("t1_count", count, 0);
    chk("t1_illegal", out_illegal, 0);
    chk("t1_imm8_w32", w_out_imm8, 32'hFFFF_FFF9);

    // full field decode
    in_valid = 1'b1; in_instr = 16'hAAAA;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t2_valid", out_valid, 1);
    chk("t2_opcode", out_opcode, 3'b101);
    chk("t2_op", out_op, 2'b01);
    chk("t2_aluop", out_aluop, 2'b01);
    chk("t2_shift", out_shift, 2'b01);
    chk("t2_rn", out_rn, 2);
    chk("t2_rd", out_rd, 5);
    chk("t2_rm", out_rm, 2);
    chk("t2_imm5", out_imm5, 16'h000A);
    chk("t2_imm8", out_imm8, 16'hFFAA);
    tick();
    chk("t2_drained", out_valid, 0);

    // back-pressure: five of six accepted
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) vals[i] = 16'hA001 + 16'(i);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_instr = vals[i];
      chk($sformatf("t3_in_ready%0d", i), in_ready, (i < 5) ? 1 : 0);
      tick();
    end
    in_valid = 1'b0;
    chk("t3_count", count, 4);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_valid", out_valid, 1);
    chk("t3_hold_imm8", out_imm8, 16'h0001);
    tick();
    chk("t3_hold2_imm8", out_imm8, 16'h0001);
    chk("t3_hold2_count", count, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_drain_v%0d", k), out_valid, 1);
      chk($sformatf("t3_drain_d%0d", k), out_imm8, 16'(k + 1));
      tick();
    end
    chk("t3_end_valid", out_valid, 0);
    chk("t3_end_count", count, 0);

    // flush with a concurrent push at count 3
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = 16'hB010 + 16'(i);
      tick();
    end
    chk("t4_pre_count", count, 3);
    in_instr = 16'hB0FF; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_count", count, 0);
    chk("t4_valid", out_valid, 0);
    chk("t4_ready", in_ready, 1);
    out_ready = 1'b1;
    tick(); tick();
    chk("t4_no_ghost", out_valid, 0);

    // illegal encodings
    in_valid = 1'b1; in_instr = 16'h0000;
    tick();
    in_instr = 16'hD800;
    tick();
    chk("t5_ill_0000", out_illegal, ILL);
    in_instr = 16'hA000;
    tick();
    in_valid = 1'b0;
    chk("t5_ill_D800", out_illegal, ILL);
    tick();
    chk("t5_ill_A000", out_illegal, 0);
    chk("t5_valid", out_valid, 1);
    tick();

    // asynchronous reset mid-drain
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = 16'hD0F9;
      tick();
    end
    in_valid = 1'b0;
    chk("t6_pre_count", count, 2);
    chk("t6_pre_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_count", count, 0);
    chk("t6_opcode", out_opcode, 0);
    chk("t6_imm8", out_imm8, 0);
    chk("t6_imm8_w32", w_out_imm8, 0);
    chk("t6_rd", out_rd, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_ready", in_ready, 1);
    chk("t6_valid_after", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
